spi_slave_if: RTL and testbench



---
 rtl/spi_slave_if.sv | 183 ++++++++++++++++++
 tb/tb_spi_slave_if.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI mode-0 peripheral: synchronises sclk/cs_n/mosi into clk, shifts MSB-first
// in both directions, with a one-word TX holding register and a pulsed RX output.
module spi_slave_if #(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_FILL   = WIDTH'(8'hFF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   sclk_d1_q, sclk_d1_d;
  logic                   cs_d1_q, cs_d1_d;
  logic                   armed_q, armed_d;
  logic [0:0]             state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   word_done_q, word_done_d;
  logic [WIDTH-1:0]       tx_shr_q, tx_shr_d;
  logic [WIDTH-1:0]       rx_shr_q, rx_shr_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_underrun_q, tx_underrun_d;
  logic                   word_load;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s & sclk_d1_q;
  // A frame only starts once cs_n has been seen high after reset, so a select
  // line already low at reset release is not mistaken for a new frame.
  assign cs_fall   = armed_q & ~cs_s & cs_d1_q;
  assign cs_rise   = cs_s & ~cs_d1_q;

  always_comb begin
    sclk_sync_d   = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sync_vld_d    = {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
    sclk_d1_d     = sclk_s;
    cs_d1_d       = cs_s;
    armed_d       = armed_q | (sync_vld_q[SYNC_STAGES-1] & cs_s);
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_done_d   = word_done_q;
    tx_shr_d      = tx_shr_q;
    rx_shr_d      = rx_shr_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    word_load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d     = S_ACTIVE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          word_load   = 1'b1;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          tx_shr_d    = '0;
          rx_shr_d    = '0;
        end else if (sclk_rise) begin
          rx_shr_d = {rx_shr_q[WIDTH-2:0], mosi_s};
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d   = {rx_shr_q[WIDTH-2:0], mosi_s};
            rx_valid_d  = 1'b1;
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (word_done_q) begin
            word_load   = 1'b1;
            word_done_d = 1'b0;
          end else begin
            tx_shr_d = {tx_shr_q[WIDTH-2:0], 1'b0};
          end
        end
      end
    endcase

    if (word_load) begin
      if (hold_full_q) begin
        tx_shr_d    = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shr_d      = IDLE_FILL;
        tx_underrun_d = 1'b1;
      end
    end

    // Host write is evaluated after the load decision: no same-cycle bypass.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sync_vld_q    <= '0;
      sclk_d1_q     <= 1'b0;
      cs_d1_q       <= 1'b1;
      armed_q       <= 1'b0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      word_done_q   <= 1'b0;
      tx_shr_q      <= '0;
      rx_shr_q      <= '0;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sync_vld_q    <= sync_vld_d;
      sclk_d1_q     <= sclk_d1_d;
      cs_d1_q       <= cs_d1_d;
      armed_q       <= armed_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_done_q   <= word_done_d;
      tx_shr_q      <= tx_shr_d;
      rx_shr_q      <= rx_shr_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign busy        = (state_q == S_ACTIVE);
  assign miso_oe     = busy;
  assign miso        = busy & tx_shr_q[WIDTH-1];
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a bit-banged SPI controller drives frames while
// monitors compare received RX words and sampled MISO words against queues.
module tb_spi_slave_if;

  localparam int HALF = 5;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_err = 0;
  int unr_cnt = 0;
  int miso_nb = 0;
  logic [7:0] miso_sh = '0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];

  spi_slave_if #(.WIDTH(8), .SYNC_STAGES(SYNC), .IDLE_FILL(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RX monitor: every rx_valid pulse must match the next expected word.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (exp_rx_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL rx_unexpected: got %0h expected none at %0t", rx_data, $time);
      end else begin
        chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
      end
    end
    if (tx_underrun) unr_cnt++;
  end

  // MISO monitor: controller samples on raw sclk rise; partial words discarded.
  always @(posedge sclk or posedge cs_n or posedge rst) begin
    if (rst || cs_n) begin
      miso_nb = 0;
    end else if (miso_oe) begin
      miso_sh = {miso_sh[6:0], miso};
      miso_nb++;
      if (miso_nb == 8) begin
        miso_nb = 0;
        if (exp_miso_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL miso_unexpected: got %0h expected none", miso_sh);
        end else begin
          chk("miso_word", 32'(miso_sh), 32'(exp_miso_q.pop_front()));
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] d);
    bit done = 0;
    @(posedge clk); #1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        @(posedge clk); #1;
        done = 1;
      end
    end
    tx_valid = 1'b0;
    chk("tx_accept", 32'(done), 32'd1);
  endtask

  task automatic sclk_bit(input logic b, input logic last);
    mosi = b;
    wait_clk(HALF);
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
    if (last) cs_n = 1'b1;
  endtask

  // mode: 0 plain, 1 supply tx2 mid-frame, 2 present tx2 in the cs_n-fall load cycle
  task automatic frame(input int nw, input logic [7:0] m0, input logic [7:0] m1,
                       input logic [7:0] e0, input logic [7:0] e1, input int mode,
                       input logic [7:0] tx2, input int unr_exp, input bit chk_rdy);
    logic [7:0] mo[2];
    int unr0;
    mo[0] = m0;
    mo[1] = m1;
    unr0 = unr_cnt;
    exp_rx_q.push_back(m0);
    exp_miso_q.push_back(e0);
    if (nw > 1) begin
      exp_rx_q.push_back(m1);
      exp_miso_q.push_back(e1);
    end
    @(posedge clk); #1;
    cs_n = 1'b0;
    if (mode == 2) begin
      wait_clk(SYNC);
      tx_data  = tx2;
      tx_valid = 1'b1;
      chk("tx_ready_at_load", 32'(tx_ready), 32'd1);
      wait_clk(1);
      tx_valid = 1'b0;
    end
    wait_clk(8);
    chk("busy_active", 32'(busy), 32'd1);
    chk("miso_oe_active", 32'(miso_oe), 32'd1);
    if (chk_rdy) chk("tx_ready_after_load", 32'(tx_ready), 32'd1);
    if (mode == 1) send_tx(tx2);
    for (int w = 0; w < nw; w++)
      for (int b = 7; b >= 0; b--)
        sclk_bit(mo[w][b], (w == nw - 1) && (b == 0));
    wait_clk(10);
    chk("underrun_count", 32'(unr_cnt - unr0), 32'(unr_exp));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_underrun", 32'(tx_underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Single byte
    send_tx(8'hA5);
    chk("tx_ready_full", 32'(tx_ready), 32'd0);
    frame(1, 8'h3C, 8'h00, 8'hA5, 8'h00, 0, 8'h00, 0, 1);
    wait_clk(10);

    // Back-to-back, second word supplied during word 0
    send_tx(8'h12);
    frame(2, 8'hF0, 8'h0F, 8'h12, 8'h34, 1, 8'h34, 0, 0);
    wait_clk(10);

    // Underrun: holding empty at select
    frame(1, 8'h96, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 1, 1);
    wait_clk(10);

    // Abort after 5 bits, then a clean frame
    send_tx(8'hC3);
    @(posedge clk); #1;
    cs_n = 1'b0;
    wait_clk(8);
    sclk_bit(1'b1, 1'b0);
    sclk_bit(1'b1, 1'b0);
    sclk_bit(1'b0, 1'b0);
    sclk_bit(1'b0, 1'b0);
    sclk_bit(1'b1, 1'b0);
    wait_clk(HALF);
    cs_n = 1'b1;
    wait_clk(10);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_miso_oe", 32'(miso_oe), 32'd0);
    send_tx(8'h81);
    frame(1, 8'h5A, 8'h00, 8'h81, 8'h00, 0, 8'h00, 0, 1);
    wait_clk(10);

    // Reset mid-frame with cs_n held low afterwards
    send_tx(8'h77);
    @(posedge clk); #1;
    cs_n = 1'b0;
    wait_clk(8);
    sclk_bit(1'b1, 1'b0);
    sclk_bit(1'b0, 1'b0);
    sclk_bit(1'b1, 1'b0);
    wait_clk(2);
    rst = 1'b1;
    #1;
    chk("mid_rst_miso", 32'(miso), 32'd0);
    chk("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("mid_rst_rx_data", 32'(rx_data), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    begin
      int unr0;
      unr0 = unr_cnt;
      wait_clk(8);
      for (int i = 0; i < 8; i++) sclk_bit(1'b1, 1'b0);
      wait_clk(5);
      chk("held_low_busy", 32'(busy), 32'd0);
      chk("held_low_miso_oe", 32'(miso_oe), 32'd0);
      chk("held_low_underrun", 32'(unr_cnt - unr0), 32'd0);
    end
    cs_n = 1'b1;
    wait_clk(10);
    send_tx(8'hE7);
    frame(1, 8'h99, 8'h00, 8'hE7, 8'h00, 0, 8'h00, 0, 1);
    wait_clk(10);

    // tx_valid in the load cycle with holding empty: no bypass
    frame(2, 8'hA1, 8'h1A, 8'hFF, 8'h55, 2, 8'h55, 1, 0);
    wait_clk(10);

    chk("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    chk("miso_queue_drained", 32'(exp_miso_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
